// File: rtl/fp8_pkg.sv
// Shared constants and types for the fixed-point to FP8 conversion path.
// FP8 layout: sign[7], exp[6:4] (bias 3), frac[3:0]; exp=0 is denormal.
package fp8_pkg;

  localparam int FP8_EXP_BIAS   = 3;
  localparam int FP8_EXP_W      = 3;
  localparam int FP8_FRAC_W     = 4;
  localparam int FP8_DENORM_EXP = -2;
  localparam logic [6:0] FP8_MAX_MAG = 7'h7F;

  // Q6.6 two's complement fixed-point input
  localparam int FXP_W    = 12;
  localparam int FXP_FRAC = 6;

  // Normalisation counter: starts at the MSB index of the 11-bit magnitude
  // and stops at the index where the value falls into the denormal range.
  localparam logic [3:0] NORM_E_INIT = 4'd10;
  localparam logic [3:0] NORM_E_MIN  = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } enc_state_t;

endpackage

// File: rtl/fp8_encoder.sv
// Iterative Q6.6 -> FP8 converter. Takes the magnitude, then left-shifts
// one bit per cycle until the leading one reaches bit 10 or the exponent
// counter hits the denormal floor. Truncates (round toward zero).
module fp8_encoder
  import fp8_pkg::*;
#(
  parameter logic [6:0] SAT_MAG = FP8_MAX_MAG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FXP_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_overflow,
  output logic             out_inexact,
  output logic             out_zero,
  output logic             busy
);

  enc_state_t       state_q, state_d;
  logic [FXP_W-1:0] data_q, data_d;
  logic [10:0]      sh_q, sh_d;
  logic [3:0]       e_q, e_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic             inex_q, inex_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [FXP_W-1:0] mag_s;
  logic [2:0]       exp_s;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    sh_d       = sh_q;
    e_d        = e_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    inex_d     = inex_q;
    zero_d     = zero_q;
    mag_s      = data_q[FXP_W-1] ? (12'd0 - data_q) : data_q;
    // e is 4..10 when a normal stop happens, so modulo-8 arithmetic on the
    // low bits gives e-3 exactly.
    exp_s      = e_q[2:0] - 3'(FP8_EXP_BIAS);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = ABS;
        end else begin
          state_d = IDLE;
        end
      end
      ABS: begin
        if (mag_s == 12'd0) begin
          out_data_d = 8'h00;
          ovf_d      = 1'b0;
          inex_d     = 1'b0;
          zero_d     = 1'b1;
          state_d    = DONE;
        end else if (mag_s[11]) begin
          // only -2048 reaches here: |value| = 32 is out of range
          out_data_d = {1'b1, SAT_MAG};
          ovf_d      = 1'b1;
          inex_d     = 1'b1;
          zero_d     = (SAT_MAG == 7'h00);
          state_d    = DONE;
        end else begin
          sh_d    = mag_s[10:0];
          e_d     = NORM_E_INIT;
          state_d = NORM;
        end
      end
      NORM: begin
        if (!sh_q[10] && (e_q > NORM_E_MIN)) begin
          sh_d = {sh_q[9:0], 1'b0};
          e_d  = e_q - 4'd1;
        end else if (sh_q[10]) begin
          out_data_d = {data_q[FXP_W-1], exp_s, sh_q[9:6]};
          ovf_d      = 1'b0;
          inex_d     = |sh_q[5:0];
          zero_d     = 1'b0;
          state_d    = DONE;
        end else begin
          // denormal: sh[9:6] holds the original mag[3:0], nothing is lost
          out_data_d = {data_q[FXP_W-1], 3'b000, sh_q[9:6]};
          ovf_d      = 1'b0;
          inex_d     = 1'b0;
          zero_d     = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= 12'd0;
      sh_q        <= 11'd0;
      e_q         <= 4'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      inex_q      <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sh_q        <= sh_d;
      e_q         <= e_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      inex_q      <= inex_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = ovf_q;
  assign out_inexact  = inex_q;
  assign out_zero     = zero_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fp8_encoder.sv
// Directed bench for fp8_encoder: table of conversions with expected FP8
// code, flags and latency, plus backpressure and mid-conversion reset.
module tb_fp8_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_overflow;
  logic        out_inexact;
  logic        out_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fp8_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact),
    .out_zero     (out_zero),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] din;
    logic [7:0]  dout;
    logic        ovf;
    logic        inex;
    logic        zero;
    int          lat;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one conversion, wait for the result, check it, then drain it.
  task automatic run_vec(input vec_t v, input bit drain);
    int n;
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = v.din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    chk("latency", n, v.lat);
    chk("out_data", {24'd0, out_data}, {24'd0, v.dout});
    chk("out_overflow", {31'd0, out_overflow}, {31'd0, v.ovf});
    chk("out_inexact", {31'd0, out_inexact}, {31'd0, v.inex});
    chk("out_zero", {31'd0, out_zero}, {31'd0, v.zero});
    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    if (drain) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
      chk("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
      chk("busy_after_drain", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    // 1.0 is 2^0 -> biased exponent 3; frac = next four bits below the leading one
    vecs[0]  = '{12'd64,   8'h30, 1'b0, 1'b0, 1'b0, 6};
    vecs[1]  = '{12'd72,   8'h32, 1'b0, 1'b0, 1'b0, 6};
    vecs[2]  = '{12'hFA0,  8'hB8, 1'b0, 1'b0, 1'b0, 6};
    vecs[3]  = '{12'd48,   8'h28, 1'b0, 1'b0, 1'b0, 7};
    vecs[4]  = '{12'd70,   8'h31, 1'b0, 1'b1, 1'b0, 6};
    vecs[5]  = '{12'd2047, 8'h7F, 1'b0, 1'b1, 1'b0, 2};
    vecs[6]  = '{12'd5,    8'h05, 1'b0, 1'b0, 1'b0, 8};
    vecs[7]  = '{12'd16,   8'h10, 1'b0, 1'b0, 1'b0, 8};
    vecs[8]  = '{12'd0,    8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{12'h800,  8'hFF, 1'b1, 1'b1, 1'b0, 1};
    vecs[10] = '{12'hFFF,  8'h81, 1'b0, 1'b0, 1'b0, 8};
    vecs[11] = '{12'd1024, 8'h70, 1'b0, 1'b0, 1'b0, 2};
    vecs[12] = '{12'd100,  8'h39, 1'b0, 1'b0, 1'b0, 6};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 12'd0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {29'd0, out_overflow, out_inexact, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], 1'b1);
    end

    // Backpressure: result and flags held, a new request is ignored
    run_vec(vecs[1], 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'd5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data", {24'd0, out_data}, 32'h32);
      chk("bp_flags", {29'd0, out_overflow, out_inexact, out_zero}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_no_spurious_accept", {31'd0, busy}, 32'd0);

    // Reset in the middle of normalising 1.0
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'd64;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[12], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
